// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam word_t C_NOP_INSTR = 32'h0000_0000;
    localparam word_t C_RESET_PC  = 32'h0000_0000;
    localparam word_t C_PC_STEP   = 32'd4;

    // Wraps modulo 2^32, so 32'hFFFF_FFFC + 4 yields 0.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + C_PC_STEP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with hold (stall) and bubble (flush).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr_q,    w_instr_d;
    logic [31:0] r_pc_plus4_q, w_pc_plus4_d;
    logic        r_valid_q,    w_valid_d;

    // Stall outranks flush: a held instruction must not be lost to a bubble.
    always_comb begin
        w_instr_d    = r_instr_q;
        w_pc_plus4_d = r_pc_plus4_q;
        w_valid_d    = r_valid_q;
        if (!i_stall) begin
            if (i_flush) begin
                w_instr_d    = NOP_INSTR;
                w_pc_plus4_d = 32'h0000_0000;
                w_valid_d    = 1'b0;
            end else begin
                w_instr_d    = i_instr;
                w_pc_plus4_d = i_pc_plus4;
                w_valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_q    <= NOP_INSTR;
            r_pc_plus4_q <= 32'h0000_0000;
            r_valid_q    <= 1'b0;
        end else begin
            r_instr_q    <= w_instr_d;
            r_pc_plus4_q <= w_pc_plus4_d;
            r_valid_q    <= w_valid_d;
        end
    end

    assign o_instr    = r_instr_q;
    assign o_pc_plus4 = r_pc_plus4_q;
    assign o_valid    = r_valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : MIPS instruction fetch: PCF, next-PC select, wait-state FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic        jrD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] PCJumpD,
    input  logic [31:0] PCjrD,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    fetch_state_t r_state_q,  w_state_d;
    logic [31:0]  r_pcf_q,    w_pcf_d;
    logic [31:0]  r_pend_pc_q, w_pend_pc_d;

    logic        w_redir;
    logic        w_done;
    logic        w_flush;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4f;

    // A branch stalled in decode is not yet committed, so its redirect is masked.
    assign w_redir     = (PCSrcD | JumpD | jrD) & ~StallD;
    assign w_target    = jrD   ? PCjrD   :
                         JumpD ? PCJumpD : PCBranchD;
    assign w_done      = imem_ready & ((r_state_q == FETCH) | (r_state_q == WAIT));
    assign w_pc_plus4f = pc_plus4(r_pcf_q);

    always_comb begin
        w_state_d   = r_state_q;
        w_pcf_d     = r_pcf_q;
        w_pend_pc_d = r_pend_pc_q;
        case (r_state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (w_redir) begin
                        w_pcf_d = w_target;
                    end else if (!StallF) begin
                        w_pcf_d = w_pc_plus4f;
                    end
                end else if (w_redir) begin
                    w_pend_pc_d = w_target;
                    w_state_d   = DRAIN;
                end else begin
                    w_state_d = WAIT;
                end
            end
            WAIT: begin
                // The address must stay put until the access drains, so a
                // redirect here is parked in pend_pc and the word discarded.
                if (w_redir) begin
                    w_pend_pc_d = w_target;
                    w_state_d   = DRAIN;
                end else if (imem_ready) begin
                    w_state_d = FETCH;
                    if (!StallF) begin
                        w_pcf_d = w_pc_plus4f;
                    end
                end
            end
            DRAIN: begin
                if (w_redir) begin
                    w_pend_pc_d = w_target;
                end
                if (imem_ready) begin
                    w_pcf_d   = w_redir ? w_target : r_pend_pc_q;
                    w_state_d = FETCH;
                end
            end
            default: begin
                w_state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= FETCH;
            r_pcf_q     <= RESET_PC;
            r_pend_pc_q <= 32'h0000_0000;
        end else begin
            r_state_q   <= w_state_d;
            r_pcf_q     <= w_pcf_d;
            r_pend_pc_q <= w_pend_pc_d;
        end
    end

    assign w_flush = w_redir | ~w_done | (r_state_q == DRAIN) | (w_done & StallF);

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (reset),
        .i_stall    (StallD),
        .i_flush    (w_flush),
        .i_instr    (imem_rdata),
        .i_pc_plus4 (w_pc_plus4f),
        .o_instr    (InstrD),
        .o_pc_plus4 (PCPlus4D),
        .o_valid    (ValidD)
    );

    assign imem_addr = r_pcf_q;
    assign imem_req  = ~reset;
    assign FetchBusy = (r_state_q != FETCH) | ~imem_ready;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed, table-driven self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    typedef struct {
        logic        rdy, sf, sd, br, j, jr;
        logic [31:0] bt, jt, rt;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_instr, e_pc4;
        logic        e_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, PCSrcD, JumpD, jrD;
    logic [31:0] PCBranchD, PCJumpD, PCjrD;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_req, imem_ready;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD, FetchBusy;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .JumpD      (JumpD),
        .jrD        (jrD),
        .PCBranchD  (PCBranchD),
        .PCJumpD    (PCJumpD),
        .PCjrD      (PCjrD),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusy  (FetchBusy)
    );

    // Instruction memory contents: each word is tagged with its own address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic add(input logic rdy, sf, sd, br, j, jr,
                       input logic [31:0] bt, jt, rt, ea,
                       input logic eb,
                       input logic [31:0] ei, ep,
                       input logic ev);
        vec_t v;
        v.rdy = rdy; v.sf = sf; v.sd = sd; v.br = br; v.j = j; v.jr = jr;
        v.bt = bt; v.jt = jt; v.rt = rt;
        v.e_addr = ea; v.e_busy = eb; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //   rdy sf sd br j  jr  bt        jt        rt            addr          busy instr                pc4           v
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h0,        0, w(32'h0),            32'h4,        1);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h4,        0, w(32'h4),            32'h8,        1);
        add(0, 0, 0, 0, 0, 0, 0,        0,        0,            32'h8,        1, 32'h0,               32'h0,        0);
        add(0, 0, 0, 0, 0, 0, 0,        0,        0,            32'h8,        1, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h8,        1, w(32'h8),            32'hC,        1);
        add(1, 0, 0, 1, 0, 0, 32'h40,   0,        0,            32'hC,        0, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h40,       0, w(32'h40),           32'h44,       1);
        add(1, 0, 0, 1, 1, 1, 32'h60,   32'h80,   32'h20,       32'h44,       0, 32'h0,               32'h0,        0);
        add(0, 0, 0, 0, 0, 0, 0,        0,        0,            32'h20,       1, 32'h0,               32'h0,        0);
        add(0, 0, 0, 0, 0, 1, 0,        0,        32'h100,      32'h20,       1, 32'h0,               32'h0,        0);
        add(0, 0, 0, 0, 0, 0, 0,        0,        0,            32'h20,       1, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h20,       1, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h100,      0, w(32'h100),          32'h104,      1);
        add(1, 0, 0, 0, 1, 0, 0,        32'hC,    0,            32'h104,      0, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'hC,        0, w(32'hC),            32'h10,       1);
        add(1, 1, 1, 1, 0, 0, 32'h200,  0,        0,            32'h10,       0, w(32'hC),            32'h10,       1);
        add(1, 1, 1, 1, 0, 0, 32'h200,  0,        0,            32'h10,       0, w(32'hC),            32'h10,       1);
        add(1, 1, 1, 1, 0, 0, 32'h200,  0,        0,            32'h10,       0, w(32'hC),            32'h10,       1);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h10,       0, w(32'h10),           32'h14,       1);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h14,       0, w(32'h14),           32'h18,       1);
        add(1, 1, 0, 0, 0, 0, 0,        0,        0,            32'h18,       0, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h18,       0, w(32'h18),           32'h1C,       1);
        add(1, 0, 0, 0, 0, 1, 0,        0,        32'hFFFF_FFFC, 32'h1C,      0, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'hFFFF_FFFC, 0, w(32'hFFFF_FFFC),   32'h0,        1);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h0,        0, w(32'h0),            32'h4,        1);
        add(0, 0, 0, 1, 0, 0, 32'h300,  0,        0,            32'h4,        1, 32'h0,               32'h0,        0);
        add(0, 0, 0, 0, 1, 0, 0,        32'h400,  0,            32'h4,        1, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h4,        1, 32'h0,               32'h0,        0);
        add(0, 0, 0, 0, 0, 0, 0,        0,        0,            32'h400,      1, 32'h0,               32'h0,        0);
        add(1, 0, 0, 1, 0, 0, 32'h500,  0,        0,            32'h400,      1, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h400,      1, 32'h0,               32'h0,        0);
        add(1, 0, 0, 0, 0, 0, 0,        0,        0,            32'h500,      0, w(32'h500),          32'h504,      1);
        add(0, 0, 0, 0, 0, 1, 0,        0,        32'h600,      32'h504,      1, 32'h0,               32'h0,        0);

        reset = 1'b1;
        {StallF, StallD, PCSrcD, JumpD, jrD, imem_ready} = '0;
        PCBranchD = '0; PCJumpD = '0; PCjrD = '0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_addr",   imem_addr,       32'h0);
        chk("reset_req",    {31'b0, imem_req}, 32'h0);
        chk("reset_instr",  InstrD,          32'h0);
        chk("reset_pc4",    PCPlus4D,        32'h0);
        chk("reset_valid",  {31'b0, ValidD}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            imem_ready = vecs[i].rdy;
            StallF     = vecs[i].sf;
            StallD     = vecs[i].sd;
            PCSrcD     = vecs[i].br;
            JumpD      = vecs[i].j;
            jrD        = vecs[i].jr;
            PCBranchD  = vecs[i].bt;
            PCJumpD    = vecs[i].jt;
            PCjrD      = vecs[i].rt;
            imem_rdata = w(imem_addr);
            #1;
            chk($sformatf("v%0d_addr", i),  imem_addr,             vecs[i].e_addr);
            chk($sformatf("v%0d_busy", i),  {31'b0, FetchBusy},    {31'b0, vecs[i].e_busy});
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req},     32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_instr", i), InstrD,                vecs[i].e_instr);
            chk($sformatf("v%0d_pc4", i),   PCPlus4D,              vecs[i].e_pc4);
            chk($sformatf("v%0d_valid", i), {31'b0, ValidD},       {31'b0, vecs[i].e_valid});
            @(negedge clk);
        end

        // Reset mid-DRAIN (pend_pc=0x600, PCF=0x504) clears PCF without a clock edge.
        {StallF, StallD, PCSrcD, JumpD, jrD, imem_ready} = '0;
        #2 reset = 1'b1;
        #1;
        chk("drain_rst_addr", imem_addr,         32'h0);
        chk("drain_rst_req",  {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = w(imem_addr);
        #1;
        chk("post_rst_addr", imem_addr,          32'h0);
        chk("post_rst_busy", {31'b0, FetchBusy}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_instr", InstrD,            w(32'h0));
        chk("post_rst_pc4",   PCPlus4D,          32'h4);
        chk("post_rst_valid", {31'b0, ValidD},   32'h1);

        // Reset with a valid instruction in D clears IF/ID asynchronously.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_instr", InstrD,           32'h0);
        chk("async_rst_pc4",   PCPlus4D,         32'h0);
        chk("async_rst_valid", {31'b0, ValidD},  32'h0);
        chk("async_rst_addr",  imem_addr,        32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
